countdown_ctrl: RTL and testbench

Run/pause controller for the 30-second countdown timer: debounces the raw push-button, converts each press into a single-cycle pulse, and runs the IDLE/RUN/PAUSE/DONE state machine. In RUN it emits one-cycle `count_enable` ticks at a fixed rate. It sits directly upstream of the BCD countdown counter, drives that counter's `count_enable` and the board's state LED, and takes back the counter's zero flag as `done`.

---
 rtl/countdown_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_countdown_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : countdown_ctrl
// Purpose  : Run/pause controller for the 30-second countdown timer.
//            Synchronizes and debounces the raw push-button, turns each
//            press into a one-cycle pulse, and sequences IDLE/RUN/PAUSE/DONE.
//            While running it issues one-cycle count_enable ticks every
//            TICK_DIV clocks toward the downstream BCD counter.
// Ports    : clk          - system clock, rising edge
//            rst_n        - asynchronous reset, active-high (legacy name)
//            in           - raw push-button, active-high, asynchronous
//            done         - counter-at-zero flag from the BCD counter
//            count_enable - one-cycle decrement tick to the counter
//            stateled     - 1 while in RUN
// Revision : 1.0 - initial release
// ============================================================================
module countdown_ctrl #(
  parameter int SAMPLE_DIV   = 100_000,
  parameter int DEBOUNCE_LEN = 4,
  parameter int TICK_DIV     = 100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  input  logic done,
  output logic count_enable,
  output logic stateled
);

  localparam int c_samp_w = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int c_tick_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_samp_w-1:0] c_sample_last = c_samp_w'(SAMPLE_DIV - 1);
  localparam logic [c_tick_w-1:0] c_tick_last   = c_tick_w'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Two-flop synchronizer for the asynchronous button input.
  logic r_sync1, r_sync2;
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= in;
      r_sync2 <= r_sync1;
    end
  end

  // Free-running sample prescaler.
  logic [c_samp_w-1:0] r_samp_cnt;
  logic                w_strobe;
  assign w_strobe = (r_samp_cnt == c_sample_last);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_samp_cnt <= '0;
    end else if (w_strobe) begin
      r_samp_cnt <= '0;
    end else begin
      r_samp_cnt <= r_samp_cnt + c_samp_w'(1);
    end
  end

  // Debounce shift register; the newest sample enters at bit 0.
  logic [DEBOUNCE_LEN-1:0] r_shift;
  logic [DEBOUNCE_LEN-1:0] w_shift_next;

  generate
    if (DEBOUNCE_LEN > 1) begin : g_shift_multi
      assign w_shift_next = {r_shift[DEBOUNCE_LEN-2:0], r_sync2};
    end else begin : g_shift_single
      assign w_shift_next = r_sync2;
    end
  endgenerate

  logic r_level, r_level_d;
  logic w_press;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_shift   <= '0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
    end else begin
      if (w_strobe) begin
        r_shift <= w_shift_next;
      end
      // Level only changes on a unanimous window; mixed windows hold it.
      if (&r_shift) begin
        r_level <= 1'b1;
      end else if (~|r_shift) begin
        r_level <= 1'b0;
      end
      r_level_d <= r_level;
    end
  end

  // Rising edge of the debounced level only; release produces nothing.
  assign w_press = r_level & ~r_level_d;

  // Run/pause state machine.
  state_t r_state, w_state_next;
  logic   w_tick_clr;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_tick_clr   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_press) begin
          w_state_next = S_RUN;
          w_tick_clr   = 1'b1;
        end
      end
      S_RUN: begin
        // Reaching zero wins over a simultaneous press.
        if (done) begin
          w_state_next = S_DONE;
        end else if (w_press) begin
          w_state_next = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (w_press) begin
          w_state_next = S_RUN;
        end
      end
      S_DONE: begin
        w_state_next = S_DONE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Tick prescaler: advances only in RUN, so a pause keeps the partial second.
  logic [c_tick_w-1:0] r_tick_cnt;
  logic                w_tick_last;
  assign w_tick_last = (r_tick_cnt == c_tick_last);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_tick_cnt <= '0;
    end else if (w_tick_clr) begin
      r_tick_cnt <= '0;
    end else if (r_state == S_RUN) begin
      if (w_tick_last) begin
        r_tick_cnt <= '0;
      end else begin
        r_tick_cnt <= r_tick_cnt + c_tick_w'(1);
      end
    end
  end

  // Registered outputs. The LED follows the state being entered so it
  // changes on the same edge as the state register.
  logic r_count_en, r_led;
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_count_en <= 1'b0;
      r_led      <= 1'b0;
    end else begin
      r_count_en <= (r_state == S_RUN) && w_tick_last && !done;
      r_led      <= (w_state_next == S_RUN);
    end
  end

  assign count_enable = r_count_en;
  assign stateled     = r_led;

endmodule
`default_nettype wire

// File: tb/tb_countdown_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_countdown_ctrl
// Purpose  : Self-checking bench for countdown_ctrl with small dividers.
//            An edge-indexed reference model (input history, sample list,
//            accumulated run time) predicts stateled/count_enable each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_countdown_ctrl;

  localparam int SD = 2;
  localparam int DL = 4;
  localparam int TD = 10;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic tb_in = 1'b0;
  logic tb_done = 1'b0;
  logic count_enable;
  logic stateled;

  always #5 clk = ~clk;

  countdown_ctrl #(
    .SAMPLE_DIV  (SD),
    .DEBOUNCE_LEN(DL),
    .TICK_DIV    (TD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in          (tb_in),
    .done        (tb_done),
    .count_enable(count_enable),
    .stateled    (stateled)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state, indexed by edges since reset release.
  int  m_n;
  bit  m_hist[$];
  bit  m_samp[$];
  bit  m_level;
  bit  m_pend;
  int  m_state;
  int  m_acc;
  bit  e_led;
  bit  e_ce;

  typedef struct {
    bit in_v;
    bit done_v;
    bit led;
    bit ce;
  } vec_t;
  vec_t vecs[24];

  function automatic void chk(string nm, logic act, logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s edge=%0d actual=%0b required=%0b", nm, m_n, act, exp);
    end
  endfunction

  function automatic void chk_int(string nm, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s edge=%0d actual=%0d required=%0d", nm, m_n, act, exp);
    end
  endfunction

  function automatic void model_reset();
    m_n = 0;
    m_hist.delete();
    m_samp.delete();
    m_level = 0;
    m_pend  = 0;
    m_state = M_IDLE;
    m_acc   = 0;
    e_led   = 0;
    e_ce    = 0;
  endfunction

  // One rising edge: in_v/done_v are the values present just before it.
  function automatic void model_edge(bit in_v, bit done_v);
    bit p, synced, all1, all0;
    m_n++;
    m_hist.push_back(in_v);
    // The button reaches the debouncer two edges late.
    synced = (m_n >= 3) ? m_hist[m_n-3] : 1'b0;
    p = m_pend;
    m_pend = 0;
    all1 = 1;
    all0 = 1;
    for (int k = 0; k < DL; k++) begin
      bit b;
      b = (m_samp.size() > k) ? m_samp[m_samp.size()-1-k] : 1'b0;
      if (b) all0 = 0; else all1 = 0;
    end
    if (all1 && !m_level) m_pend = 1;
    if (all1) m_level = 1;
    else if (all0) m_level = 0;
    if ((m_n % SD) == 0) m_samp.push_back(synced);
    e_ce = (m_state == M_RUN) && !done_v && ((m_acc % TD) == TD - 1);
    if (m_state == M_RUN) m_acc++;
    if (m_state == M_IDLE) begin
      if (p) begin m_state = M_RUN; m_acc = 0; end
    end else if (m_state == M_RUN) begin
      if (done_v) m_state = M_DONE;
      else if (p) m_state = M_PAUSE;
    end else if (m_state == M_PAUSE) begin
      if (p) m_state = M_RUN;
    end
    e_led = (m_state == M_RUN);
  endfunction

  task automatic step(input bit in_v, input bit done_v);
    tb_in   = in_v;
    tb_done = done_v;
    @(posedge clk);
    model_edge(in_v, done_v);
    @(negedge clk);
    chk("stateled", stateled, e_led);
    chk("count_enable", count_enable, e_ce);
  endtask

  // Asynchronous assert between edges, outputs checked before any edge.
  task automatic apply_reset();
    #2 rst_n = 1'b1;
    #1;
    chk("rst_stateled", stateled, 1'b0);
    chk("rst_count_enable", count_enable, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog edge=%0d actual=timeout required=finish", m_n);
    $fatal(1, "watchdog");
  end

  initial begin
    int rises, first_n, pulses, last_ce, wait_n, cnt, done_left;
    bit prev_led, prev_ce;

    // Held press from reset: debounce completes at edge 11, RUN at 12,
    // first tick 10 edges later.
    for (int i = 0; i < 24; i++) begin
      vecs[i].in_v   = 1'b1;
      vecs[i].done_v = 1'b0;
      vecs[i].led    = (i + 1 >= 12);
      vecs[i].ce     = (i + 1 == 22);
    end

    model_reset();
    apply_reset();
    for (int i = 0; i < 24; i++) begin
      step(vecs[i].in_v, vecs[i].done_v);
      chk("tbl_led", stateled, vecs[i].led);
      chk("tbl_ce", count_enable, vecs[i].ce);
    end

    // Glitching input (low at every sampled edge), then a stable rise.
    apply_reset();
    rises = 0;
    prev_led = 0;
    for (int n = 1; n <= 30; n++) begin
      step((n % 2) == 1, 1'b0);
      if (stateled && !prev_led) rises++;
      prev_led = stateled;
    end
    chk_int("glitch_presses", rises, 0);
    first_n = 0;
    for (int n = 31; n <= 50; n++) begin
      step(1'b1, 1'b0);
      if (stateled && !prev_led) begin
        rises++;
        if (first_n == 0) first_n = n;
      end
      prev_led = stateled;
    end
    chk_int("stable_presses", rises, 1);
    chk("stable_led_latency", (first_n != 0) && (first_n - 30 <= 12), 1'b1);

    // Tick rate over 100 cycles of uninterrupted RUN.
    pulses = 0;
    last_ce = 0;
    prev_ce = 0;
    for (int n = 51; n <= 150; n++) begin
      step(1'b1, 1'b0);
      if (count_enable) begin
        if (prev_ce) chk("ce_width", 1'b1, 1'b0);
        if (pulses > 0) chk_int("ce_spacing", n - last_ce, TD);
        pulses++;
        last_ce = n;
      end
      prev_ce = count_enable;
    end
    chk_int("ce_pulses", pulses, 10);

    // Pause with 6 held in the prescaler: release, then time the next press.
    repeat (16) step(1'b0, 1'b0);
    for (int t = 0; t < 20; t++) begin
      int r, fe, pe;
      r  = m_n + 1;
      fe = ((r + 2) % 2 == 0) ? r + 2 : r + 3;
      pe = fe + 8;
      if (((m_acc + (pe - 1 - m_n)) % TD) == 5) break;
      step(1'b0, 1'b0);
    end
    wait_n = 0;
    while (stateled && wait_n < 30) begin
      step(1'b1, 1'b0);
      wait_n++;
    end
    chk("pause_reached", stateled, 1'b0);
    pulses = 0;
    for (int n = 0; n < 50; n++) begin
      step(1'b1, 1'b0);
      if (count_enable) pulses++;
    end
    chk_int("pause_ticks", pulses, 0);
    chk("pause_led", stateled, 1'b0);
    repeat (16) step(1'b0, 1'b0);
    wait_n = 0;
    while (!stateled && wait_n < 30) begin
      step(1'b1, 1'b0);
      wait_n++;
    end
    chk("resume_reached", stateled, 1'b1);
    cnt = 0;
    while (!count_enable && cnt < 20) begin
      step(1'b1, 1'b0);
      cnt++;
    end
    chk_int("resume_first_tick", cnt, 4);

    // done asserted in the cycle the prescaler sits at TD-1.
    wait_n = 0;
    while (!((m_state == M_RUN) && ((m_acc % TD) == TD - 1)) && wait_n < 20) begin
      step(1'b1, 1'b0);
      wait_n++;
    end
    step(1'b1, 1'b1);
    chk("done_tick_suppressed", count_enable, 1'b0);
    chk("done_led", stateled, 1'b0);
    rises = 0;
    for (int n = 0; n < 48; n++) begin
      step((n / 16) == 1, 1'b0);
      if (stateled) rises++;
    end
    chk_int("done_ignores_press", rises, 0);

    // Held button gives one press; reset mid-RUN; debounce starts over.
    apply_reset();
    rises = 0;
    prev_led = 0;
    for (int n = 0; n < 200; n++) begin
      step(1'b1, 1'b0);
      if (stateled && !prev_led) rises++;
      prev_led = stateled;
    end
    chk_int("held_presses", rises, 1);
    wait_n = 0;
    while (!e_ce && wait_n < 20) begin
      step(1'b1, 1'b0);
      wait_n++;
    end
    chk("pre_reset_tick", count_enable, 1'b1);
    apply_reset();
    cnt = 0;
    while (!stateled && cnt < 30) begin
      step(1'b1, 1'b0);
      cnt++;
    end
    chk_int("post_reset_run_edge", cnt, 12);

    // Randomized input runs against the model.
    for (int seg = 0; seg < 20; seg++) begin
      apply_reset();
      done_left = 0;
      cnt = 0;
      while (cnt < 150) begin
        int len;
        bit v;
        len = $urandom_range(1, 12);
        v   = $urandom_range(0, 1);
        for (int j = 0; j < len; j++) begin
          bit d;
          if (done_left > 0) begin
            d = 1;
            done_left--;
          end else begin
            d = 0;
            if ($urandom_range(0, 59) == 0) done_left = $urandom_range(1, 3);
          end
          step(v, d);
          cnt++;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
